// File: rtl/btn_step.sv
// Pushbutton debounce and step generator: synchronises the raw active-low key,
// filters bounce, and emits one clean btn_out pulse (plus press strobe) per step.
module btn_step #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int PULSE_WIDTH     = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic btn_out,
    output logic press,
    output logic held
);

    localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_B = (REPEAT_PERIOD > PULSE_WIDTH) ? REPEAT_PERIOD : PULSE_WIDTH;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] DB_C     = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] PW_C     = CW'(PULSE_WIDTH);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        HELD,
        REPEAT,
        DB_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] pcnt_q, pcnt_d;
    logic          sync1_q, sync2_q;
    logic          held_q, held_d;
    logic          press_q;
    logic          btn_out_q, btn_out_d;
    logic          step;
    logic          s;

    assign s = sync2_q;

    // Synchroniser flops idle at 1 so a key held through reset still needs a full debounce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pcnt_q    <= '0;
            held_q    <= 1'b0;
            press_q   <= 1'b0;
            btn_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pcnt_q    <= pcnt_d;
            held_q    <= held_d;
            press_q   <= step;
            btn_out_q <= btn_out_d;
        end
    end

    // A release seen in HELD/REPEAT takes priority over a coincident repeat step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        held_d  = held_q;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!s) begin
                    state_d = DB_PRESS;
                    cnt_d   = ONE_C;
                end
            end
            DB_PRESS: begin
                if (s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_C) begin
                    step    = 1'b1;
                    held_d  = 1'b1;
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            HELD: begin
                if (s) begin
                    state_d = DB_RELEASE;
                    cnt_d   = ONE_C;
                end else if (REPEAT_EN != 0 && cnt_q == RD_LAST) begin
                    step    = 1'b1;
                    state_d = REPEAT;
                    cnt_d   = '0;
                end else if (REPEAT_EN != 0) begin
                    cnt_d = cnt_q + ONE_C;
                end else begin
                    cnt_d = '0;
                end
            end
            REPEAT: begin
                if (s) begin
                    state_d = DB_RELEASE;
                    cnt_d   = ONE_C;
                end else if (cnt_q == RP_LAST) begin
                    step  = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            DB_RELEASE: begin
                if (!s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_C) begin
                    held_d  = 1'b0;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // btn_out is the registered form of (pcnt != 0), so it stays high PULSE_WIDTH cycles.
    always_comb begin
        pcnt_d    = pcnt_q;
        btn_out_d = 1'b0;
        if (step) begin
            pcnt_d    = PW_C;
            btn_out_d = 1'b1;
        end else if (pcnt_q != '0) begin
            pcnt_d    = pcnt_q - ONE_C;
            btn_out_d = (pcnt_q > ONE_C);
        end
    end

    assign btn_out = btn_out_q;
    assign press   = press_q;
    assign held    = held_q;

endmodule

// File: tb/tb_btn_step.sv
// Scoreboard bench for btn_step: stimulus queues expected step/held events,
// a negedge monitor pops and compares them as the DUTs produce outputs.
module tb_btn_step;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam int PW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic btn_n = 1'b1;
    logic btnOut, press, held;
    logic btnOut0, press0, held0;

    btn_step #(
        .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .PULSE_WIDTH(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_n),
        .btn_out(btnOut), .press(press), .held(held)
    );

    btn_step #(
        .DEBOUNCE_CYCLES(DB), .REPEAT_EN(0), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .PULSE_WIDTH(PW)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_n),
        .btn_out(btnOut0), .press(press0), .held(held0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int   cyc;
        logic val;
    } heldEv_t;

    int      pressQ[$];
    int      press0Q[$];
    int      riseQ[$];
    heldEv_t heldQ[$];
    heldEv_t ev;
    int      nVec = 0;
    int      nMis = 0;
    int      base;
    logic [7:0] pat;
    logic    prevBtn  = 1'b0;
    logic    prevHeld = 1'b0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nVec++;
        if (actual != expected) begin
            nMis++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic waitCyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Drive the key and hold it until the negedge following edge untilCyc.
    task automatic applyStimulus(input logic b, input int untilCyc);
        btn_n = b;
        waitCyc(untilCyc);
    endtask

    task automatic expectStep(input int c, input bit isRepeat);
        pressQ.push_back(c);
        riseQ.push_back(c);
        if (!isRepeat) press0Q.push_back(c);
    endtask

    task automatic expectHeld(input int c, input logic v);
        heldEv_t e;
        e.cyc = c;
        e.val = v;
        heldQ.push_back(e);
    endtask

    task automatic checkDrained(input string name);
        checkOutput({name, " pending press"}, pressQ.size(), 0);
        checkOutput({name, " pending press (no repeat)"}, press0Q.size(), 0);
        checkOutput({name, " pending btn_out rise"}, riseQ.size(), 0);
        checkOutput({name, " pending held change"}, heldQ.size(), 0);
    endtask

    // Monitor: every press, btn_out rising edge and held change must match the queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevBtn  = btnOut;
            prevHeld = held;
        end else begin
            if (press) begin
                if (pressQ.size() == 0) checkOutput("unexpected press", cyc, -1);
                else checkOutput("press cycle", cyc, pressQ.pop_front());
            end
            if (press0) begin
                if (press0Q.size() == 0) checkOutput("unexpected press (no repeat)", cyc, -1);
                else checkOutput("press cycle (no repeat)", cyc, press0Q.pop_front());
            end
            if (btnOut && !prevBtn) begin
                if (riseQ.size() == 0) checkOutput("unexpected btn_out rise", cyc, -1);
                else checkOutput("btn_out rise cycle", cyc, riseQ.pop_front());
            end
            if (held != prevHeld) begin
                if (heldQ.size() == 0) checkOutput("unexpected held change", cyc, -1);
                else begin
                    ev = heldQ.pop_front();
                    checkOutput("held change cycle", cyc, ev.cyc);
                    checkOutput("held change value", int'(held), int'(ev.val));
                end
            end
            prevBtn  = btnOut;
            prevHeld = held;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset with the key toggling: everything stays low.
        rst_n = 1'b0;
        btn_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            btn_n = i[0];
        end
        @(negedge clk);
        checkOutput("reset btn_out", int'(btnOut), 0);
        checkOutput("reset press", int'(press), 0);
        checkOutput("reset held", int'(held), 0);
        btn_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        base = cyc + 1;
        waitCyc(base + 12);
        checkOutput("post-reset btn_out", int'(btnOut), 0);
        checkOutput("post-reset held", int'(held), 0);

        // Clean press held for 10 cycles.
        base = cyc + 1;
        expectStep(base + 6, 1'b0);
        expectHeld(base + 6, 1'b1);
        expectHeld(base + 16, 1'b0);
        applyStimulus(1'b0, base + 8);
        checkOutput("clean btn_out last high", int'(btnOut), 1);
        waitCyc(base + 9);
        checkOutput("clean btn_out low after pulse", int'(btnOut), 0);
        checkOutput("clean held", int'(held), 1);
        applyStimulus(1'b1, base + 40);
        checkDrained("clean");

        // Press bounce: never stable long enough.
        base = cyc + 1;
        pat = 8'b1100_1000;
        for (int i = 0; i < 8; i++) begin
            btn_n = pat[i];
            @(negedge clk);
        end
        applyStimulus(1'b1, base + 25);
        checkOutput("bounce btn_out", int'(btnOut), 0);
        checkOutput("bounce held", int'(held), 0);
        checkDrained("bounce");

        // Auto-repeat over a 60-cycle hold; the no-repeat DUT steps once.
        base = cyc + 1;
        expectStep(base + 6, 1'b0);
        expectStep(base + 26, 1'b1);
        expectStep(base + 34, 1'b1);
        expectStep(base + 42, 1'b1);
        expectStep(base + 50, 1'b1);
        expectStep(base + 58, 1'b1);
        expectHeld(base + 6, 1'b1);
        expectHeld(base + 66, 1'b0);
        applyStimulus(1'b0, base + 59);
        btn_n = 1'b1;
        waitCyc(base + 60);
        checkOutput("repeat pulse not truncated", int'(btnOut), 1);
        waitCyc(base + 90);
        checkOutput("no-repeat held released", int'(held0), 0);
        checkDrained("repeat");

        // Release bounce: returns to HELD once, no extra step.
        base = cyc + 1;
        expectStep(base + 6, 1'b0);
        expectHeld(base + 6, 1'b1);
        expectHeld(base + 19, 1'b0);
        applyStimulus(1'b0, base + 9);
        pat = 8'b1111_1011;
        for (int i = 0; i < 8; i++) begin
            btn_n = pat[i];
            @(negedge clk);
        end
        applyStimulus(1'b1, base + 40);
        checkDrained("release bounce");

        // Reset during the second high cycle of btn_out, key still held.
        base = cyc + 1;
        expectStep(base + 6, 1'b0);
        expectHeld(base + 6, 1'b1);
        applyStimulus(1'b0, base + 7);
        checkOutput("mid-pulse btn_out before reset", int'(btnOut), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid-pulse btn_out in reset", int'(btnOut), 0);
        checkOutput("mid-pulse held in reset", int'(held), 0);
        checkOutput("mid-pulse press in reset", int'(press), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base = cyc + 1;
        expectStep(base + 6, 1'b0);
        expectHeld(base + 6, 1'b1);
        expectHeld(base + 16, 1'b0);
        waitCyc(base + 9);
        applyStimulus(1'b1, base + 40);
        checkDrained("reset mid-pulse");

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
